led_status: RTL and testbench

LED_STATUS -- requirements
Module: led_status

---
 rtl/led_status.sv | 136 +++++++++++++
 tb/tb_led_status.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_status.sv
// Self-test status controller: tracks per-channel PASS/FAIL results across a
// run with timeout, and drives a registered LED bank with a free-running blinker.
module led_status #(
  parameter int unsigned N_CHECKS  = 2,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned BLINK_DIV = 12_500_000,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear,
  input  logic [N_CHECKS-1:0] check_pass,
  input  logic [N_CHECKS-1:0] check_fail,
  output logic [LED_W-1:0]    led,
  output logic                done,
  output logic                all_pass,
  output logic                any_fail
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {C_PEND, C_PASS, C_FAIL} chan_t;

  state_t           state_q, state_d;
  chan_t            chan_q [N_CHECKS];
  chan_t            chan_d [N_CHECKS];
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [BLK_W-1:0] blk_q;
  logic             phase_q;
  logic [LED_W-1:0] led_d;
  logic             done_d, all_pass_d, any_fail_d;
  logic             pending_c, timeout_c;

  // Next state, channel status and output values
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    for (int i = 0; i < N_CHECKS; i++) chan_d[i] = chan_q[i];
    pending_c  = 1'b0;
    timeout_c  = (tmo_q == CNT_W'(TIMEOUT - 1));
    led_d      = '0;
    done_d     = 1'b0;
    all_pass_d = 1'b0;
    any_fail_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < N_CHECKS; i++) chan_d[i] = C_PEND;
        if (!clear && start) begin
          state_d = S_RUN;
          tmo_d   = '0;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
          for (int i = 0; i < N_CHECKS; i++) chan_d[i] = C_PEND;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // Fail overrides pass; pass only resolves a pending channel
          for (int i = 0; i < N_CHECKS; i++) begin
            if (check_fail[i]) chan_d[i] = C_FAIL;
            else if (check_pass[i] && chan_q[i] == C_PEND) chan_d[i] = C_PASS;
            if (timeout_c && chan_d[i] == C_PEND) chan_d[i] = C_FAIL;
            if (chan_d[i] == C_PEND) pending_c = 1'b1;
          end
          if (timeout_c || !pending_c) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          for (int i = 0; i < N_CHECKS; i++) chan_d[i] = C_PEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output image of the current registered state
    led_d[0]   = 1'b1;
    done_d     = (state_q == S_DONE);
    all_pass_d = (state_q == S_DONE);
    for (int i = 0; i < N_CHECKS; i++) begin
      case (chan_q[i])
        C_PASS:  led_d[i+1] = 1'b1;
        C_FAIL:  led_d[i+1] = phase_q;
        default: led_d[i+1] = 1'b0;
      endcase
      if (chan_q[i] != C_PASS) all_pass_d = 1'b0;
      if (chan_q[i] == C_FAIL && state_q != S_IDLE) any_fail_d = 1'b1;
    end
    case (state_q)
      S_RUN:   led_d[LED_W-1] = phase_q;
      S_DONE:  led_d[LED_W-1] = all_pass_d ? 1'b1 : ~phase_q;
      default: led_d[LED_W-1] = 1'b0;
    endcase
  end

  // State, channel and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      for (int i = 0; i < N_CHECKS; i++) chan_q[i] <= C_PEND;
      led      <= '0;
      done     <= 1'b0;
      all_pass <= 1'b0;
      any_fail <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      for (int i = 0; i < N_CHECKS; i++) chan_q[i] <= chan_d[i];
      led      <= led_d;
      done     <= done_d;
      all_pass <= all_pass_d;
      any_fail <= any_fail_d;
    end
  end

  // Free-running blink divider; phase flips on every wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      blk_q   <= blk_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_status.sv
// Directed, table-driven bench for led_status (N_CHECKS=2, LED_W=8,
// BLINK_DIV=4, TIMEOUT=16) with hand-written timeout and reset sequences.
module tb_led_status;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear;
  logic [1:0] check_pass, check_fail;
  logic [7:0] led;
  logic       done, all_pass, any_fail;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  led_status #(.N_CHECKS(2), .LED_W(8), .BLINK_DIV(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .check_pass(check_pass), .check_fail(check_fail),
    .led(led), .done(done), .all_pass(all_pass), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  // Edges since reset release: the led image after edge n uses the phase after edge n-1
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  typedef struct packed {
    logic       st, cl;
    logic [1:0] ps, fl;
    logic [7:0] led, blk, inv;
    logic       dn, ap, af;
  } vec_t;

  vec_t tbl[$];

  function automatic logic ph();
    return 1'((((ncyc - 1) / 4) % 2) != 0);
  endfunction

  function automatic logic [7:0] mix(input logic [7:0] base, blk, inv);
    logic p;
    p = ph();
    return (base & ~blk & ~inv) | (blk & {8{p}}) | (inv & {8{~p}});
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic st, cl, input logic [1:0] ps, fl,
                     input logic [7:0] l, b, v, input logic dn, ap, af);
    vec_t x;
    x = '{st: st, cl: cl, ps: ps, fl: fl, led: l, blk: b, inv: v, dn: dn, ap: ap, af: af};
    tbl.push_back(x);
  endtask

  initial begin
    //   st  cl  pass   fail   led    blink  inv    dn ap af
    // all pass
    add(1, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b01, 2'b00, 8'h01, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b10, 2'b00, 8'h03, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h87, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 2'b00, 2'b00, 8'h87, 8'h00, 8'h00, 1, 1, 0);
    add(0, 1, 2'b00, 2'b00, 8'h87, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    // simultaneous pass+fail on ch0, events in DONE/IDLE ignored
    add(1, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b01, 2'b01, 8'h01, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b10, 2'b00, 8'h01, 8'h82, 8'h00, 0, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b11, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 1, 2'b00, 2'b00, 8'h05, 8'h02, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b11, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    // sticky FAIL on ch1, start in RUN ignored
    add(1, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b10, 8'h01, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b10, 2'b00, 8'h01, 8'h84, 8'h00, 0, 0, 1);
    add(1, 0, 2'b00, 2'b00, 8'h01, 8'h84, 8'h00, 0, 0, 1);
    add(0, 0, 2'b01, 2'b00, 8'h01, 8'h84, 8'h00, 0, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h03, 8'h04, 8'h80, 1, 0, 1);
    add(0, 1, 2'b00, 2'b00, 8'h03, 8'h04, 8'h80, 1, 0, 1);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    // clear dominates start, in IDLE and in RUN
    add(1, 1, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b11, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 8'h01, 8'h80, 8'h00, 0, 0, 0);
    add(0, 0, 2'b11, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 0, 0, 0);

    rst = 1'b0; start = 1'b0; clear = 1'b0; check_pass = '0; check_fail = '0;
    repeat (3) @(negedge clk);
    chk("reset led", led, 8'h00);
    chk("reset done", {7'd0, done}, 8'd0);
    chk("reset flags", {6'd0, all_pass, any_fail}, 8'd0);
    rst = 1'b1;

    // Idle after reset release
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle led c%0d", k), led, 8'h01);
      chk($sformatf("idle done/fail c%0d", k), {6'd0, done, any_fail}, 8'd0);
    end

    foreach (tbl[r]) begin
      start = tbl[r].st; clear = tbl[r].cl;
      check_pass = tbl[r].ps; check_fail = tbl[r].fl;
      tick();
      chk($sformatf("row%0d led", r), led, mix(tbl[r].led, tbl[r].blk, tbl[r].inv));
      chk($sformatf("row%0d done/all/any", r), {5'd0, done, all_pass, any_fail},
          {5'd0, tbl[r].dn, tbl[r].ap, tbl[r].af});
    end
    start = 1'b0; clear = 1'b0; check_pass = '0; check_fail = '0;

    // Timeout: only ch0 passes; a stray start mid-run must not restart the count
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      check_pass = (k == 2) ? 2'b01 : 2'b00;
      start      = (k == 6);
      tick();
      chk($sformatf("timeout done k%0d", k), {7'd0, done}, {7'd0, 1'(k >= 17)});
      if (k == 17) begin
        chk("timeout flags", {6'd0, all_pass, any_fail}, 8'b01);
        chk("timeout led", led, mix(8'h03, 8'h04, 8'h80));
      end
    end
    check_pass = '0; start = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("after clear led", led, 8'h01);

    // Asynchronous reset mid-run discards results
    start = 1'b1;
    tick();
    start = 1'b0; check_fail = 2'b10;
    tick();
    check_fail = '0;
    tick();
    chk("pre-reset any_fail", {7'd0, any_fail}, 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("async reset led", led, 8'h00);
    chk("async reset flags", {5'd0, done, all_pass, any_fail}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post-reset led", led, 8'h01);
    chk("post-reset any_fail", {7'd0, any_fail}, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0; check_pass = 2'b01;
    tick();
    check_pass = '0;
    tick();
    chk("post-reset run led", led, mix(8'h03, 8'h80, 8'h00));
    chk("post-reset run flags", {6'd0, done, any_fail}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
